fetch_decode_reg: RTL and testbench
===================================

Name: fetch_decode_reg

Overview:
- Fetch-to-decode pipeline register with a 1-entry skid buffer.
- Produces inst_f2d for the forwarding/hazard unit and the execute stage.
- Consumes that unit's flush and discards a configurable number of wrong-path fetch responses after a redirect.
- Supplies a canonical NOP whenever the slot is empty, so downstream opcode decode never sees stale jal/jalr/branch encodings.

Parameters:
- WIDTH, 32, instruction and PC width.
- KILL_DEPTH, 1, number of accepted fetch beats dropped after a flush (0 = none).
- NOP_INST, 32'h00000013, encoding driven on inst_f2d when valid_f2d=0.

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- pc_f  in  WIDTH  PC of fetched instruction
- inst_f  in  WIDTH  fetched instruction
- inst_valid_f  in  1  fetch beat valid
- inst_ready_f  out  1  stage can accept a beat
- stall_d  in  1  downstream stall; hold the f2d register
- flush  in  1  kill all held and in-flight instructions
- pc_f2d  out  WIDTH  registered PC
- inst_f2d  out  WIDTH  registered instruction (NOP_INST when invalid)
- valid_f2d  out  1  registered slot holds a real instruction

Behaviour:
- Reset (async, rst_n=0): valid_f2d=0, inst_f2d=NOP_INST, pc_f2d=0, skid empty, state=RUN, kill counter=0. Released synchronously on the next clk edge with rst_n=1.
- A beat is accepted when inst_valid_f && inst_ready_f.
- inst_ready_f = !skid_full. It is combinational from state only, never from inst_valid_f.
- FSM states:
  - RUN: normal flow.
  - KILL: dropping wrong-path beats.
  - The skid-full flag is orthogonal and only valid in RUN.
- Priority per cycle: flush > stall_d > normal advance.
- Flush cycle, any state:
  - Next edge: valid_f2d=0, inst_f2d=NOP_INST, skid cleared.
  - Any beat accepted in that cycle is discarded and not counted.
  - If KILL_DEPTH>0: state<=KILL, counter<=KILL_DEPTH. Otherwise state<=RUN.
  - Flush while already in KILL reloads the counter.
  - Flush overrides stall_d.
- KILL:
  - inst_ready_f=1. Each accepted beat is dropped and the counter decrements.
  - The beat that takes the counter 1->0 is dropped and state<=RUN.
  - Output register holds NOP/invalid; stall_d is ignored for output purposes.
- RUN, stall_d=0:
  - If skid full: output <= skid, then skid <= accepted beat if any, else skid empty.
  - If skid empty: output <= accepted beat, else valid_f2d<=0, inst_f2d<=NOP_INST.
  - Latency is 1 cycle from acceptance to inst_f2d when unstalled.
- RUN, stall_d=1:
  - Output register holds all fields.
  - An accepted beat is written into the empty skid. When the skid is full, inst_ready_f=0 and no beat is accepted.
- Ordering: program order is always preserved; the skid entry is always older than any newly accepted beat.
- pc_f2d is don't-care while valid_f2d=0 but holds its last value (no X).
- No beat is ever duplicated or lost outside KILL/flush.

Optional Feature:
- Macro: FETCH_PERF_CNT_EN.
- Defined: adds outputs flush_cnt[31:0] and drop_cnt[31:0].
  - flush_cnt: +1 per flush cycle.
  - drop_cnt: +1 per beat dropped in KILL or in a flush cycle.
  - Both wrap at 2^32, reset to 0 asynchronously.
- Undefined: ports and counters absent; all other behaviour identical.

Test Plan:
- Stream 4 beats (pc 0x0,0x4,0x8,0xC; inst=addi) with stall_d=0 -> each appears on inst_f2d one cycle after acceptance, valid_f2d=1, inst_ready_f constantly 1.
- With a valid beat already in the output register, assert stall_d for 3 cycles while beats 0x4,0x8 are offered -> output holds its current beat, 0x4 goes to skid, inst_ready_f=0 for the remaining stall cycles, 0x8 waits; after release the outputs are 0x4 then 0x8 on consecutive cycles, in order.
- Flush with skid full and stall_d=1, KILL_DEPTH=1 -> next cycle valid_f2d=0, inst_f2d=32'h00000013; next accepted beat dropped; the following beat (pc 0x100) appears valid.
- Flush again in the cycle after the first flush, while in KILL -> counter reloads; exactly KILL_DEPTH further beats dropped after the second flush.
- Assert rst_n=0 mid-stream with skid full -> outputs go to reset values immediately, without a clock edge; after release the first new beat passes normally.
- FETCH_PERF_CNT_EN defined: 2 flushes with KILL_DEPTH=1, one beat offered in the first flush cycle, one beat dropped in each KILL window -> flush_cnt=2, drop_cnt=3.

Source files
------------

// File: rtl/fetch_decode_reg.sv
// rtl/fetch_decode_reg.sv - fetch-to-decode pipeline register with 1-entry skid buffer and flush kill window
//
// Optional feature macro: FETCH_PERF_CNT_EN (adds flush_cnt / drop_cnt outputs).
//
// Ports:
//   clk, rst_n        core clock, asynchronous active-low reset
//   pc_f, inst_f      fetched PC / instruction
//   inst_valid_f      fetch beat valid
//   inst_ready_f      stage can accept a beat (depends only on the skid-full state)
//   stall_d           downstream stall, holds the f2d register
//   flush             kill all held and in-flight instructions
//   pc_f2d, inst_f2d  registered PC / instruction (NOP_INST when invalid)
//   valid_f2d         registered slot holds a real instruction
//   flush_cnt         (FETCH_PERF_CNT_EN) number of flush cycles
//   drop_cnt          (FETCH_PERF_CNT_EN) number of beats dropped by flush/kill
module fetch_decode_reg #(
    parameter int               WIDTH      = 32,
    parameter int               KILL_DEPTH = 1,
    parameter logic [WIDTH-1:0] NOP_INST   = WIDTH'(32'h00000013)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] pc_f,
    input  logic [WIDTH-1:0] inst_f,
    input  logic             inst_valid_f,
    output logic             inst_ready_f,
    input  logic             stall_d,
    input  logic             flush,
    output logic [WIDTH-1:0] pc_f2d,
    output logic [WIDTH-1:0] inst_f2d,
    output logic             valid_f2d
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]      flush_cnt,
    output logic [31:0]      drop_cnt
`endif
);

    localparam int CW = (KILL_DEPTH < 2) ? 1 : $clog2(KILL_DEPTH + 1);

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_KILL = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    kill_cnt_q, kill_cnt_d;
    logic             skid_full_q, skid_full_d;
    logic [WIDTH-1:0] skid_pc_q, skid_pc_d;
    logic [WIDTH-1:0] skid_inst_q, skid_inst_d;
    logic             valid_q, valid_d;
    logic [WIDTH-1:0] pc_q, pc_d;
    logic [WIDTH-1:0] inst_q, inst_d;
    logic             accept;

    // The skid is only ever filled in RUN, so in KILL this is always 1.
    assign inst_ready_f = !skid_full_q;
    assign accept       = inst_valid_f && inst_ready_f;

    always_comb begin
        state_d     = state_q;
        kill_cnt_d  = kill_cnt_q;
        skid_full_d = skid_full_q;
        skid_pc_d   = skid_pc_q;
        skid_inst_d = skid_inst_q;
        valid_d     = valid_q;
        pc_d        = pc_q;
        inst_d      = inst_q;

        if (flush) begin
            valid_d     = 1'b0;
            inst_d      = NOP_INST;
            skid_full_d = 1'b0;
            if (KILL_DEPTH > 0) begin
                state_d    = ST_KILL;
                kill_cnt_d = CW'(KILL_DEPTH);
            end else begin
                state_d = ST_RUN;
            end
        end else if (state_q == ST_KILL) begin
            // Output already holds NOP/invalid since the flush; just count drops.
            if (accept) begin
                kill_cnt_d = kill_cnt_q - CW'(1);
                if (kill_cnt_q == CW'(1)) begin
                    state_d = ST_RUN;
                end
            end
        end else if (stall_d) begin
            if (accept) begin
                skid_full_d = 1'b1;
                skid_pc_d   = pc_f;
                skid_inst_d = inst_f;
            end
        end else if (skid_full_q) begin
            // Skid entry is older than any new beat, so it drains first.
            valid_d     = 1'b1;
            pc_d        = skid_pc_q;
            inst_d      = skid_inst_q;
            skid_full_d = accept;
            if (accept) begin
                skid_pc_d   = pc_f;
                skid_inst_d = inst_f;
            end
        end else if (accept) begin
            valid_d = 1'b1;
            pc_d    = pc_f;
            inst_d  = inst_f;
        end else begin
            valid_d = 1'b0;
            inst_d  = NOP_INST;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_RUN;
            kill_cnt_q  <= '0;
            skid_full_q <= 1'b0;
            skid_pc_q   <= '0;
            skid_inst_q <= '0;
            valid_q     <= 1'b0;
            pc_q        <= '0;
            inst_q      <= NOP_INST;
        end else begin
            state_q     <= state_d;
            kill_cnt_q  <= kill_cnt_d;
            skid_full_q <= skid_full_d;
            skid_pc_q   <= skid_pc_d;
            skid_inst_q <= skid_inst_d;
            valid_q     <= valid_d;
            pc_q        <= pc_d;
            inst_q      <= inst_d;
        end
    end

    assign pc_f2d    = pc_q;
    assign inst_f2d  = inst_q;
    assign valid_f2d = valid_q;

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] flush_cnt_q, flush_cnt_d;
    logic [31:0] drop_cnt_q, drop_cnt_d;

    always_comb begin
        flush_cnt_d = flush_cnt_q;
        drop_cnt_d  = drop_cnt_q;
        if (flush) begin
            flush_cnt_d = flush_cnt_q + 32'd1;
        end
        // A beat accepted in a flush cycle or during KILL never reaches the output.
        if (accept && (flush || state_q == ST_KILL)) begin
            drop_cnt_d = drop_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flush_cnt_q <= '0;
            drop_cnt_q  <= '0;
        end else begin
            flush_cnt_q <= flush_cnt_d;
            drop_cnt_q  <= drop_cnt_d;
        end
    end

    assign flush_cnt = flush_cnt_q;
    assign drop_cnt  = drop_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_decode_reg.sv
// tb/tb_fetch_decode_reg.sv - self-checking bench for fetch_decode_reg
module tb_fetch_decode_reg;

    localparam int          W   = 32;
    localparam int          KD  = 1;
    localparam logic [31:0] NOP = 32'h00000013;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [W-1:0]  pc_f = '0;
    logic [W-1:0]  inst_f = '0;
    logic          inst_valid_f = 1'b0;
    logic          inst_ready_f;
    logic          stall_d = 1'b0;
    logic          flush = 1'b0;
    logic [W-1:0]  pc_f2d;
    logic [W-1:0]  inst_f2d;
    logic          valid_f2d;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0]   flush_cnt;
    logic [31:0]   drop_cnt;
`endif

    fetch_decode_reg #(.WIDTH(W), .KILL_DEPTH(KD), .NOP_INST(NOP)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .pc_f         (pc_f),
        .inst_f       (inst_f),
        .inst_valid_f (inst_valid_f),
        .inst_ready_f (inst_ready_f),
        .stall_d      (stall_d),
        .flush        (flush),
        .pc_f2d       (pc_f2d),
        .inst_f2d     (inst_f2d),
        .valid_f2d    (valid_f2d)
`ifdef FETCH_PERF_CNT_EN
        ,
        .flush_cnt    (flush_cnt),
        .drop_cnt     (drop_cnt)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: the stage is an in-order queue of at most one waiting beat behind
    // the output slot; a kill budget swallows beats after a flush.
    logic          m_v    = 1'b0;
    logic [31:0]   m_pc   = '0;
    logic [31:0]   m_inst = '0;
    logic [63:0]   m_wait[$];
    int            m_kill = 0;
    int            m_fc   = 0;
    int            m_dc   = 0;

    function automatic logic m_ready();
        return m_wait.size() == 0;
    endfunction

    task automatic model_reset();
        m_v = 1'b0; m_pc = '0; m_inst = '0;
        m_wait.delete(); m_kill = 0; m_fc = 0; m_dc = 0;
    endtask

    task automatic model_step();
        logic        acc;
        logic [63:0] e;
        acc = inst_valid_f && m_ready();
        if (flush) begin
            m_v = 1'b0;
            m_wait.delete();
            m_kill = KD;
            m_fc++;
            if (acc) m_dc++;
        end else if (m_kill > 0) begin
            if (acc) begin
                m_kill--;
                m_dc++;
            end
        end else if (stall_d) begin
            if (acc) m_wait.push_back({pc_f, inst_f});
        end else begin
            if (acc) m_wait.push_back({pc_f, inst_f});
            if (m_wait.size() > 0) begin
                e = m_wait.pop_front();
                m_v = 1'b1; m_pc = e[63:32]; m_inst = e[31:0];
            end else begin
                m_v = 1'b0;
            end
        end
    endtask

    task automatic drive(input logic f, input logic s, input logic v,
                         input logic [31:0] pc, input logic [31:0] inst);
        flush = f; stall_d = s; inst_valid_f = v; pc_f = pc; inst_f = inst;
        @(posedge clk);
        if (rst_n) model_step();
        #1;
    endtask

    function automatic logic [31:0] addi(input int imm);
        return 32'h00000093 | (32'(imm) << 20);
    endfunction

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        check("valid_f2d", 64'(valid_f2d), 64'(m_v));
        check("inst_f2d", 64'(inst_f2d), 64'(m_v ? m_inst : NOP));
        check("pc_f2d", 64'(pc_f2d), 64'(m_pc));
        check("inst_ready_f", 64'(inst_ready_f), 64'(m_ready()));
`ifdef FETCH_PERF_CNT_EN
        check("flush_cnt", 64'(flush_cnt), 64'(m_fc));
        check("drop_cnt", 64'(drop_cnt), 64'(m_dc));
`endif
    end

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", 64'(valid_f2d), 64'd0);
        check("rst_inst", 64'(inst_f2d), 64'(NOP));
        check("rst_pc", 64'(pc_f2d), 64'd0);
        rst_n = 1'b1;

        // Unstalled stream: one-cycle latency.
        drive(0, 0, 1, 32'h0, addi(0));
        check("s1_pc0", 64'(pc_f2d), 64'h0);
        check("s1_inst0", 64'(inst_f2d), 64'(addi(0)));
        check("s1_valid0", 64'(valid_f2d), 64'd1);
        drive(0, 0, 1, 32'h4, addi(1));
        drive(0, 0, 1, 32'h8, addi(2));
        drive(0, 0, 1, 32'hC, addi(3));
        check("s1_pcC", 64'(pc_f2d), 64'hC);
        check("s1_ready", 64'(inst_ready_f), 64'd1);

        // Stall with skid fill, then in-order drain.
        drive(0, 1, 1, 32'h4, addi(4));
        check("s2_hold_pc", 64'(pc_f2d), 64'hC);
        check("s2_ready0", 64'(inst_ready_f), 64'd0);
        drive(0, 1, 1, 32'h8, addi(8));
        drive(0, 1, 1, 32'h8, addi(8));
        check("s2_hold_pc2", 64'(pc_f2d), 64'hC);
        drive(0, 0, 1, 32'h8, addi(8));
        check("s2_pc4", 64'(pc_f2d), 64'h4);
        check("s2_inst4", 64'(inst_f2d), 64'(addi(4)));
        drive(0, 0, 1, 32'h8, addi(8));
        check("s2_pc8", 64'(pc_f2d), 64'h8);
        check("s2_inst8", 64'(inst_f2d), 64'(addi(8)));
        drive(0, 0, 0, 32'h0, 32'h0);
        check("s2_empty_valid", 64'(valid_f2d), 64'd0);
        check("s2_empty_nop", 64'(inst_f2d), 64'(NOP));

        // Flush with skid full and stall asserted.
        drive(0, 0, 1, 32'h20, addi(32));
        drive(0, 1, 1, 32'h24, addi(36));
        check("s3_skid_full", 64'(inst_ready_f), 64'd0);
        drive(1, 1, 1, 32'h28, addi(40));
        check("s3_flush_valid", 64'(valid_f2d), 64'd0);
        check("s3_flush_nop", 64'(inst_f2d), 64'(NOP));
        check("s3_kill_ready", 64'(inst_ready_f), 64'd1);
        drive(0, 0, 1, 32'h2C, addi(44));
        check("s3_dropped", 64'(valid_f2d), 64'd0);
        drive(0, 0, 1, 32'h100, addi(256));
        check("s3_pc100", 64'(pc_f2d), 64'h100);
        check("s3_valid100", 64'(valid_f2d), 64'd1);

        // Back-to-back flush reloads the kill counter.
        drive(1, 0, 0, 32'h0, 32'h0);
        drive(1, 0, 1, 32'h200, addi(512));
        drive(0, 0, 1, 32'h204, addi(516));
        check("s4_dropped", 64'(valid_f2d), 64'd0);
        drive(0, 0, 1, 32'h208, addi(520));
        check("s4_pc208", 64'(pc_f2d), 64'h208);
        check("s4_valid208", 64'(valid_f2d), 64'd1);

        // Asynchronous reset with skid full.
        drive(0, 0, 1, 32'h300, addi(3));
        drive(0, 1, 1, 32'h304, addi(4));
        flush = 0; stall_d = 0; inst_valid_f = 0;
        #2 rst_n = 1'b0;
        #1;
        check("s5_async_valid", 64'(valid_f2d), 64'd0);
        check("s5_async_inst", 64'(inst_f2d), 64'(NOP));
        check("s5_async_pc", 64'(pc_f2d), 64'd0);
        check("s5_async_ready", 64'(inst_ready_f), 64'd1);
        model_reset();
        @(posedge clk);
        #1 rst_n = 1'b1;
        drive(0, 0, 1, 32'h400, addi(7));
        check("s5_pc400", 64'(pc_f2d), 64'h400);
        check("s5_inst400", 64'(inst_f2d), 64'(addi(7)));
        drive(0, 0, 0, 32'h0, 32'h0);

        // Two flushes, counting flushes and drops.
        rst_n = 1'b0;
        #1 model_reset();
        @(posedge clk);
        #1 rst_n = 1'b1;
        drive(1, 0, 1, 32'h500, addi(1));
        drive(0, 0, 1, 32'h504, addi(2));
        drive(1, 0, 0, 32'h0, 32'h0);
        drive(0, 0, 1, 32'h508, addi(3));
        drive(0, 0, 1, 32'h50C, addi(4));
        check("s6_pc50C", 64'(pc_f2d), 64'h50C);
`ifdef FETCH_PERF_CNT_EN
        check("s6_flush_cnt", 64'(flush_cnt), 64'd2);
        check("s6_drop_cnt", 64'(drop_cnt), 64'd3);
`endif
        drive(0, 0, 0, 32'h0, 32'h0);
        drive(0, 0, 0, 32'h0, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
